// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: occupancy encoding and the packed stage payloads
// that are carried through pipe_elastic_reg instances.
package cpu_types_pkg;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

    // EX/MEM payload; halt sits in the MSB so HALT_BIT = $bits(exmem_pl_t)-1.
    typedef struct packed {
        logic        halt;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  rd;
        logic [31:0] alu_out;
        logic [31:0] store_data;
    } exmem_pl_t;

endpackage

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline stage register: 2-entry FIFO (main + skid) with valid/ready
// on both sides, hold freeze, flush-to-bubble and sticky halt capture.
//
//   count | meaning
//   ------+---------------------------------------------
//   0     | empty, out_data shows BUBBLE
//   1     | main holds the head entry
//   2     | main = head, skid = next; upstream is refused
module pipe_elastic_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned       DATA_W   = 128,
    parameter bit                HALT_EN  = 1'b1,
    parameter int unsigned       HALT_BIT = 0,
    parameter logic [DATA_W-1:0] BUBBLE   = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    output occ_t              occupancy,
    output logic              halted
);

    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    occ_t              count_q;
    logic              halt_seen_q;
    logic              accept;
    logic              pop;

    // Ready and valid depend only on registers and hold, never on the
    // opposite handshake, so stages can be chained without comb loops.
    always_comb begin
        in_ready  = (count_q < OCC_FULL) && !halt_seen_q && !hold;
        out_valid = (count_q != OCC_EMPTY) && !hold;
        out_data  = (count_q != OCC_EMPTY) ? main_q : BUBBLE;
        occupancy = count_q;
        halted    = halt_seen_q && (count_q == OCC_EMPTY);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            count_q     <= OCC_EMPTY;
            halt_seen_q <= 1'b0;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
        end else if (!hold) begin
            case (count_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data;
                        count_q <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            skid_q  <= in_data;
                            count_q <= OCC_FULL;
                        end
                        2'b01: begin
                            main_q  <= BUBBLE;
                            count_q <= OCC_EMPTY;
                        end
                        2'b11: main_q <= in_data;
                        default: ;
                    endcase
                end
                OCC_FULL: begin
                    if (pop) begin
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                        count_q <= OCC_ONE;
                    end
                end
                default: count_q <= OCC_EMPTY;
            endcase
            if (HALT_EN && accept && in_data[HALT_BIT])
                halt_seen_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Scoreboard bench for pipe_elastic_reg: a queue model of the 2-entry FIFO is
// compared against the DUT outputs every cycle, plus directed boundary checks.
module tb_pipe_elastic_reg;
    import cpu_types_pkg::*;

    localparam int unsigned DW     = 16;
    localparam logic [DW-1:0] BUB  = 16'hDEAD;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          hold = 1'b0;
    logic          flush = 1'b0;
    occ_t          occupancy;
    logic          halted;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] sb[$];
    logic          m_halt = 1'b0;
    logic          m_ir;
    logic          m_ov;
    logic          m_acc = 1'b0;
    logic          mon_en = 1'b0;

    pipe_elastic_reg #(
        .DATA_W  (DW),
        .HALT_EN (1'b1),
        .HALT_BIT(15),
        .BUBBLE  (BUB)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .hold     (hold),
        .flush    (flush),
        .occupancy(occupancy),
        .halted   (halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with
    // the inputs that will be sampled at the coming rising edge.
    always @(negedge CLK) begin
        if (mon_en) begin
            m_ir = (sb.size() < 2) && !m_halt && !hold;
            m_ov = (sb.size() > 0) && !hold;
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_ir});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            chk("occupancy", {30'd0, occupancy}, sb.size());
            chk("halted", {31'd0, halted}, {31'd0, m_halt && (sb.size() == 0)});
            chk("out_data", {16'd0, out_data}, {16'd0, (sb.size() > 0) ? sb[0] : BUB});
            m_acc = 1'b0;
            if (RST || flush) begin
                sb.delete();
                m_halt = 1'b0;
            end else begin
                if (m_ov && out_ready) void'(sb.pop_front());
                if (m_ir && in_valid) begin
                    sb.push_back(in_data);
                    m_acc = 1'b1;
                    if (in_data[15]) m_halt = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d);
        logic done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge CLK);
            if (m_acc) done = 1'b1;
        end
        #1;
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        @(posedge CLK); #1;
        mon_en = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, {16'd0, BUB});
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(DW'(i));
        idle(3);

        // backpressure into the skid slot
        out_ready = 1'b0;
        send(16'h000A);
        send(16'h000B);
        chk("skid_full_ready", {31'd0, in_ready}, 32'd0);
        fork
            send(16'h000C);
            begin
                idle(2);
                out_ready = 1'b1;
            end
        join
        idle(4);

        // hold freeze
        out_ready = 1'b0;
        send(16'h0005);
        hold = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h0006;
        out_ready = 1'b1;
        idle(3);
        hold = 1'b0;
        in_valid = 1'b0;
        idle(3);

        // flush beats hold, accept and pop
        out_ready = 1'b0;
        send(16'h0001);
        send(16'h0002);
        flush = 1'b1;
        hold = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h0077;
        out_ready = 1'b1;
        idle(1);
        flush = 1'b0;
        hold = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", {30'd0, occupancy}, 32'd0);
        chk("flush_data", {16'd0, out_data}, {16'd0, BUB});
        idle(2);

        // halt capture and drain
        out_ready = 1'b0;
        send(16'h0002);
        send(16'h8003);
        in_valid = 1'b1;
        in_data = 16'h0004;
        idle(3);
        chk("halt_refuse", {31'd0, in_ready}, 32'd0);
        chk("halt_pre2", {31'd0, halted}, 32'd0);
        out_ready = 1'b1;
        idle(1);
        chk("halt_pre1", {31'd0, halted}, 32'd0);
        idle(1);
        chk("halt_drained", {31'd0, halted}, 32'd1);
        in_valid = 1'b0;
        idle(1);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        chk("halt_flush_clr", {31'd0, halted}, 32'd0);
        chk("halt_flush_rdy", {31'd0, in_ready}, 32'd1);
        send(16'h8001);
        idle(2);
        chk("halt_again", {31'd0, halted}, 32'd1);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        chk("halt_rst_clr", {31'd0, halted}, 32'd0);
        idle(2);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
